// File: rtl/ex_wb_stage.sv
// Execute stage and EX/WB pipeline register for the 8-bit pipelined core.
// Owns the register file, EX forwarding and the write-through bypass on the ID read ports.
module ex_wb_stage #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ID_EX_Reg_Write,
   input  logic              ID_EX_ALU_OP,
   input  logic [DATA_W-1:0] ID_EX_Data1,
   input  logic [DATA_W-1:0] ID_EX_Data2,
   input  logic [ADDR_W-1:0] ID_EX_RD,
   input  logic [ADDR_W-1:0] ID_EX_RS1,
   input  logic [ADDR_W-1:0] ID_EX_RS2,
   input  logic [ADDR_W-1:0] RS1_Addr,
   input  logic [ADDR_W-1:0] RS2_Addr,
   output logic [DATA_W-1:0] RS1_Data,
   output logic [DATA_W-1:0] RS2_Data,
   output logic              EX_WB_Reg_Write,
   output logic [ADDR_W-1:0] EX_WB_RD,
   output logic [DATA_W-1:0] EX_WB_Result,
   output logic              Carry,
   output logic [CNT_W-1:0]  WB_Count
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic              ex_wb_we_q;
   logic [ADDR_W-1:0] ex_wb_rd_q;
   logic [DATA_W-1:0] ex_wb_res_q;
   logic              ex_wb_carry_q;
   logic              carry_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rf_q [DEPTH];

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W:0]   sum_w;
   logic [DATA_W-1:0] res_d;
   logic              carry_d;

   always_comb begin
      op_a = ID_EX_Data1;
      op_b = ID_EX_Data2;
      if (ex_wb_we_q && (ex_wb_rd_q == ID_EX_RS1)) op_a = ex_wb_res_q;
      if (ex_wb_we_q && (ex_wb_rd_q == ID_EX_RS2)) op_b = ex_wb_res_q;
   end

   // Shift amount is always the low three bits of opB, independent of DATA_W.
   always_comb begin
      sum_w   = {1'b0, op_a} + {1'b0, op_b};
      res_d   = sum_w[DATA_W-1:0];
      carry_d = sum_w[DATA_W];
      if (ID_EX_ALU_OP) begin
         res_d   = op_a << op_b[2:0];
         carry_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ex_wb_we_q    <= 1'b0;
         ex_wb_rd_q    <= '0;
         ex_wb_res_q   <= '0;
         ex_wb_carry_q <= 1'b0;
      end else begin
         ex_wb_we_q    <= ID_EX_Reg_Write;
         ex_wb_rd_q    <= ID_EX_RD;
         ex_wb_res_q   <= res_d;
         ex_wb_carry_q <= carry_d;
      end
   end

   // Commit of the EX/WB entry happens on the same edge that refills EX/WB.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         carry_q <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      end else if (ex_wb_we_q) begin
         carry_q           <= ex_wb_carry_q;
         cnt_q             <= cnt_q + CNT_W'(1);
         rf_q[ex_wb_rd_q]  <= ex_wb_res_q;
      end
   end

   always_comb begin
      RS1_Data = rf_q[RS1_Addr];
      if (ex_wb_we_q && (ex_wb_rd_q == RS1_Addr)) RS1_Data = ex_wb_res_q;
   end

   always_comb begin
      RS2_Data = rf_q[RS2_Addr];
      if (ex_wb_we_q && (ex_wb_rd_q == RS2_Addr)) RS2_Data = ex_wb_res_q;
   end

   assign EX_WB_Reg_Write = ex_wb_we_q;
   assign EX_WB_RD        = ex_wb_rd_q;
   assign EX_WB_Result    = ex_wb_res_q;
   assign Carry           = carry_q;
   assign WB_Count        = cnt_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: reset, ALU ops, carry, forwarding, bypass, counter wrap.
module tb_ex_wb_stage;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       ID_EX_Reg_Write = 1'b0;
   logic       ID_EX_ALU_OP = 1'b0;
   logic [7:0] ID_EX_Data1 = '0;
   logic [7:0] ID_EX_Data2 = '0;
   logic [2:0] ID_EX_RD = '0;
   logic [2:0] ID_EX_RS1 = '0;
   logic [2:0] ID_EX_RS2 = '0;
   logic [2:0] RS1_Addr = '0;
   logic [2:0] RS2_Addr = '0;
   logic [7:0] RS1_Data;
   logic [7:0] RS2_Data;
   logic       EX_WB_Reg_Write;
   logic [2:0] EX_WB_RD;
   logic [7:0] EX_WB_Result;
   logic       Carry;
   logic [15:0] WB_Count;

   int vecs = 0;
   int errs = 0;

   ex_wb_stage dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .ID_EX_Reg_Write (ID_EX_Reg_Write),
      .ID_EX_ALU_OP    (ID_EX_ALU_OP),
      .ID_EX_Data1     (ID_EX_Data1),
      .ID_EX_Data2     (ID_EX_Data2),
      .ID_EX_RD        (ID_EX_RD),
      .ID_EX_RS1       (ID_EX_RS1),
      .ID_EX_RS2       (ID_EX_RS2),
      .RS1_Addr        (RS1_Addr),
      .RS2_Addr        (RS2_Addr),
      .RS1_Data        (RS1_Data),
      .RS2_Data        (RS2_Data),
      .EX_WB_Reg_Write (EX_WB_Reg_Write),
      .EX_WB_RD        (EX_WB_RD),
      .EX_WB_Result    (EX_WB_Result),
      .Carry           (Carry),
      .WB_Count        (WB_Count)
   );

   always #5 Clk = ~Clk;

   task automatic drive(input logic rw, input logic op, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2);
      ID_EX_Reg_Write = rw;
      ID_EX_ALU_OP    = op;
      ID_EX_Data1     = d1;
      ID_EX_Data2     = d2;
      ID_EX_RD        = rd;
      ID_EX_RS1       = rs1;
      ID_EX_RS2       = rs2;
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd7, 3'd7);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      vecs++; if (EX_WB_Reg_Write !== 1'b0) begin errs++; $display("FAIL rst_we got %0b exp 0", EX_WB_Reg_Write); end
      vecs++; if (EX_WB_Result !== 8'h00) begin errs++; $display("FAIL rst_res got %h exp 00", EX_WB_Result); end
      vecs++; if (WB_Count !== 16'd0) begin errs++; $display("FAIL rst_cnt got %0d exp 0", WB_Count); end
      drive(1'b1, 1'b0, 8'h55, 8'h00, 3'd1, 3'd6, 3'd7);
      step();
      vecs++; if (EX_WB_Reg_Write !== 1'b1) begin errs++; $display("FAIL mid_we got %0b exp 1", EX_WB_Reg_Write); end
      bubble();
      Reset = 1'b0;
      #1;
      vecs++; if (EX_WB_Reg_Write !== 1'b0) begin errs++; $display("FAIL arst_we got %0b exp 0", EX_WB_Reg_Write); end
      vecs++; if (EX_WB_RD !== 3'd0) begin errs++; $display("FAIL arst_rd got %0d exp 0", EX_WB_RD); end
      vecs++; if (EX_WB_Result !== 8'h00) begin errs++; $display("FAIL arst_res got %h exp 00", EX_WB_Result); end
      vecs++; if (Carry !== 1'b0) begin errs++; $display("FAIL arst_carry got %0b exp 0", Carry); end
      vecs++; if (WB_Count !== 16'd0) begin errs++; $display("FAIL arst_cnt got %0d exp 0", WB_Count); end
      for (int a = 0; a < 8; a++) begin
         RS1_Addr = 3'(a);
         #1;
         vecs++; if (RS1_Data !== 8'h00) begin errs++; $display("FAIL arst_rf%0d got %h exp 00", a, RS1_Data); end
      end
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      step();
      RS1_Addr = 3'd1;
      #1;
      vecs++; if (RS1_Data !== 8'h00) begin errs++; $display("FAIL arst_nowrite got %h exp 00", RS1_Data); end
      vecs++; if (WB_Count !== 16'd0) begin errs++; $display("FAIL arst_cnt2 got %0d exp 0", WB_Count); end
   endtask

   task automatic test_add();
      drive(1'b1, 1'b0, 8'h05, 8'h03, 3'd1, 3'd6, 3'd7);
      step();
      vecs++; if (EX_WB_Result !== 8'h08) begin errs++; $display("FAIL add_res got %h exp 08", EX_WB_Result); end
      bubble();
      step();
      RS1_Addr = 3'd1;
      #1;
      vecs++; if (RS1_Data !== 8'h08) begin errs++; $display("FAIL add_rf got %h exp 08", RS1_Data); end
      vecs++; if (WB_Count !== 16'd1) begin errs++; $display("FAIL add_cnt got %0d exp 1", WB_Count); end
      vecs++; if (Carry !== 1'b0) begin errs++; $display("FAIL add_carry got %0b exp 0", Carry); end
   endtask

   task automatic test_carry();
      drive(1'b1, 1'b0, 8'hF0, 8'h20, 3'd2, 3'd6, 3'd7);
      step();
      vecs++; if (EX_WB_Result !== 8'h10) begin errs++; $display("FAIL cy_res got %h exp 10", EX_WB_Result); end
      vecs++; if (Carry !== 1'b0) begin errs++; $display("FAIL cy_early got %0b exp 0", Carry); end
      bubble();
      step();
      vecs++; if (Carry !== 1'b1) begin errs++; $display("FAIL cy_set got %0b exp 1", Carry); end
      drive(1'b1, 1'b1, 8'h03, 8'hF9, 3'd6, 3'd7, 3'd7);
      step();
      vecs++; if (Carry !== 1'b1) begin errs++; $display("FAIL cy_hold got %0b exp 1", Carry); end
      vecs++; if (EX_WB_Result !== 8'h06) begin errs++; $display("FAIL sll_res got %h exp 06", EX_WB_Result); end
      bubble();
      step();
      vecs++; if (Carry !== 1'b0) begin errs++; $display("FAIL cy_clr got %0b exp 0", Carry); end
      vecs++; if (WB_Count !== 16'd3) begin errs++; $display("FAIL cy_cnt got %0d exp 3", WB_Count); end
      RS2_Addr = 3'd2;
      #1;
      vecs++; if (RS2_Data !== 8'h10) begin errs++; $display("FAIL cy_rf2 got %h exp 10", RS2_Data); end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 8'h01, 8'h01, 3'd3, 3'd6, 3'd7);
      step();
      drive(1'b1, 1'b1, 8'h00, 8'h02, 3'd4, 3'd3, 3'd7);
      step();
      vecs++; if (EX_WB_Result !== 8'h08) begin errs++; $display("FAIL fwd_res got %h exp 08", EX_WB_Result); end
      bubble();
      step();
      RS1_Addr = 3'd4;
      RS2_Addr = 3'd3;
      #1;
      vecs++; if (RS1_Data !== 8'h08) begin errs++; $display("FAIL fwd_r4 got %h exp 08", RS1_Data); end
      vecs++; if (RS2_Data !== 8'h02) begin errs++; $display("FAIL fwd_r3 got %h exp 02", RS2_Data); end
      vecs++; if (WB_Count !== 16'd5) begin errs++; $display("FAIL fwd_cnt got %0d exp 5", WB_Count); end
   endtask

   task automatic test_bypass();
      drive(1'b1, 1'b0, 8'h7A, 8'h00, 3'd5, 3'd6, 3'd7);
      step();
      RS1_Addr = 3'd5;
      RS2_Addr = 3'd5;
      #1;
      vecs++; if (RS1_Data !== 8'h7A) begin errs++; $display("FAIL byp_p1 got %h exp 7a", RS1_Data); end
      vecs++; if (RS2_Data !== 8'h7A) begin errs++; $display("FAIL byp_p2 got %h exp 7a", RS2_Data); end
      drive(1'b0, 1'b0, 8'h11, 8'h22, 3'd5, 3'd6, 3'd7);
      step();
      bubble();
      step();
      vecs++; if (RS1_Data !== 8'h7A) begin errs++; $display("FAIL bub_r5 got %h exp 7a", RS1_Data); end
      vecs++; if (WB_Count !== 16'd6) begin errs++; $display("FAIL bub_cnt got %0d exp 6", WB_Count); end
   endtask

   task automatic test_wrap();
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      drive(1'b1, 1'b0, 8'h12, 8'h01, 3'd0, 3'd6, 3'd7);
      repeat (65535) step();
      bubble();
      step();
      vecs++; if (WB_Count !== 16'hFFFF) begin errs++; $display("FAIL wrap_max got %0d exp 65535", WB_Count); end
      drive(1'b1, 1'b0, 8'h12, 8'h01, 3'd0, 3'd6, 3'd7);
      step();
      bubble();
      step();
      vecs++; if (WB_Count !== 16'd0) begin errs++; $display("FAIL wrap_zero got %0d exp 0", WB_Count); end
      RS1_Addr = 3'd0;
      #1;
      vecs++; if (RS1_Data !== 8'h13) begin errs++; $display("FAIL r0_write got %h exp 13", RS1_Data); end
   endtask

   initial begin
      bubble();
      #12;
      @(negedge Clk);
      Reset = 1'b1;
      test_reset();
      test_add();
      test_carry();
      test_back_to_back();
      test_bypass();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
